// File: rtl/fire_ctrl_pkg.sv
// Shared types and address-width helpers for the fire-module layer controllers.
package fire_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN_LAST,
        DONE
    } state_e;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ofm_writeback.sv
// Output-RAM writeback: serialises DSP_NO ofm lanes per sampled pixel.
module ofm_writeback
    import fire_ctrl_pkg::*;
#(
    parameter int WOUT   = 32,
    parameter int DSP_NO = 32,
    localparam int NPIX  = WOUT * WOUT,
    localparam int SW    = addr_w(DSP_NO),
    localparam int OAW   = addr_w(DSP_NO * NPIX),
    localparam int QW    = addr_w(NPIX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           layer_sample,
    output logic           ofm_wr_en,
    output logic [SW-1:0]  ofm_sel,
    output logic [OAW-1:0] ofm_wr_addr,
    output logic [QW-1:0]  q_cnt,
    output logic           overrun
);

    logic           act_q, act_d;
    logic [SW-1:0]  k_q, k_d;
    logic [QW-1:0]  q_q, q_d;
    logic [OAW-1:0] a_q, a_d;
    logic           ovr_q, ovr_d;

    always_comb begin
        act_d = act_q;
        k_d   = k_q;
        q_d   = q_q;
        a_d   = a_q;
        ovr_d = ovr_q;
        if (layer_sample) begin
            if (act_q) ovr_d = 1'b1;
            else       act_d = 1'b1;
        end
        // a_q always tracks k*NPIX + q, so a new burst needs no load
        if (act_q) begin
            if (k_q == SW'(DSP_NO - 1)) begin
                act_d = 1'b0;
                k_d   = '0;
                q_d   = q_q + QW'(1);
                a_d   = OAW'(q_q) + OAW'(1);
            end else begin
                k_d = k_q + SW'(1);
                a_d = a_q + OAW'(NPIX);
            end
        end
        if (clear) begin
            act_d = 1'b0;
            k_d   = '0;
            q_d   = '0;
            a_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= 1'b0;
            k_q   <= '0;
            q_q   <= '0;
            a_q   <= '0;
            ovr_q <= 1'b0;
        end else begin
            act_q <= act_d;
            k_q   <= k_d;
            q_q   <= q_d;
            a_q   <= a_d;
            ovr_q <= ovr_d;
        end
    end

    assign ofm_wr_en   = act_q;
    assign ofm_sel     = k_q;
    assign ofm_wr_addr = a_q;
    assign q_cnt       = q_q;
    assign overrun     = ovr_q;

endmodule

// File: rtl/fire5_squeeze_ctrl.sv
// Fire5 squeeze layer controller: streams ifm reads channel-major,
// hands ofm writeback to ofm_writeback and tracks layer completion.
module fire5_squeeze_ctrl
    import fire_ctrl_pkg::*;
#(
    parameter int WOUT   = 32,
    parameter int CHIN   = 256,
    parameter int DSP_NO = 32,
    parameter int WIDTH  = 16,
    localparam int NPIX  = WOUT * WOUT,
    localparam int IAW   = addr_w(CHIN * NPIX),
    localparam int OAW   = addr_w(DSP_NO * NPIX),
    localparam int SW    = addr_w(DSP_NO)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stall,
    output logic           ifm_rd_en,
    output logic [IAW-1:0] ifm_rd_addr,
    output logic           layer_en,
    input  logic           layer_sample,
    output logic [SW-1:0]  ofm_sel,
    output logic           ofm_wr_en,
    output logic [OAW-1:0] ofm_wr_addr,
    output logic           busy,
    output logic           done,
    input  logic           ram_feedback,
    output logic           overrun
);

    localparam int CW = addr_w(CHIN);
    localparam int PW = addr_w(NPIX);
    localparam int QW = addr_w(NPIX + 1);

    if (CHIN < DSP_NO || WIDTH < 1) begin : g_bad_cfg
        $error("fire5_squeeze_ctrl: CHIN must be >= DSP_NO");
    end

    state_e         state_q, state_d;
    logic [CW-1:0]  c_q, c_d;
    logic [PW-1:0]  p_q, p_d;
    logic [IAW-1:0] addr_q, addr_d;
    logic           len_q, len_d;
    logic           rd_en;
    logic           last_c;
    logic           wb_clear;
    logic           wb_active;
    logic [QW-1:0]  wb_q;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        p_d     = p_q;
        addr_d  = addr_q;
        rd_en   = (state_q == RUN) && !stall;
        len_d   = rd_en;
        last_c  = (c_q == CW'(CHIN - 1));
        unique case (state_q)
            IDLE: begin
                c_d    = '0;
                p_d    = '0;
                addr_d = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (rd_en) begin
                    if (!last_c) begin
                        c_d    = c_q + CW'(1);
                        addr_d = addr_q + IAW'(NPIX);
                    end else if (p_q == PW'(NPIX - 1)) begin
                        state_d = DRAIN_LAST;
                        c_d     = '0;
                        p_d     = '0;
                        addr_d  = '0;
                    end else begin
                        c_d    = '0;
                        p_d    = p_q + PW'(1);
                        addr_d = IAW'(p_q) + IAW'(1);
                    end
                end
            end
            DRAIN_LAST: begin
                if (wb_q == QW'(NPIX) && !wb_active) state_d = DONE;
            end
            DONE: begin
                if (ram_feedback) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            p_q     <= '0;
            addr_q  <= '0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            p_q     <= p_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign wb_clear = (state_q == IDLE);

    ofm_writeback #(
        .WOUT   (WOUT),
        .DSP_NO (DSP_NO)
    ) u_wb (
        .clk          (clk),
        .rst          (rst),
        .clear        (wb_clear),
        .layer_sample (layer_sample),
        .ofm_wr_en    (wb_active),
        .ofm_sel      (ofm_sel),
        .ofm_wr_addr  (ofm_wr_addr),
        .q_cnt        (wb_q),
        .overrun      (overrun)
    );

    assign ofm_wr_en   = wb_active;
    assign ifm_rd_en   = rd_en;
    assign ifm_rd_addr = addr_q;
    assign layer_en    = len_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN_LAST);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fire5_squeeze_ctrl.sv
// Directed bench for fire5_squeeze_ctrl at WOUT=2, CHIN=4, DSP_NO=2.
module tb_fire5_squeeze_ctrl;

    localparam int WOUT   = 2;
    localparam int CHIN   = 4;
    localparam int DSP_NO = 2;
    localparam int WIDTH  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       layer_sample = 1'b0;
    logic       ram_feedback = 1'b0;
    logic       ifm_rd_en;
    logic [3:0] ifm_rd_addr;
    logic       layer_en;
    logic [0:0] ofm_sel;
    logic       ofm_wr_en;
    logic [2:0] ofm_wr_addr;
    logic       busy;
    logic       done;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    fire5_squeeze_ctrl #(
        .WOUT   (WOUT),
        .CHIN   (CHIN),
        .DSP_NO (DSP_NO),
        .WIDTH  (WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .ifm_rd_en    (ifm_rd_en),
        .ifm_rd_addr  (ifm_rd_addr),
        .layer_en     (layer_en),
        .layer_sample (layer_sample),
        .ofm_sel      (ofm_sel),
        .ofm_wr_en    (ofm_wr_en),
        .ofm_wr_addr  (ofm_wr_addr),
        .busy         (busy),
        .done         (done),
        .ram_feedback (ram_feedback),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_rd_en"}, ifm_rd_en, 0);
        chk({tag, "_rd_addr"}, ifm_rd_addr, 0);
        chk({tag, "_layer_en"}, layer_en, 0);
        chk({tag, "_wr_en"}, ofm_wr_en, 0);
        chk({tag, "_wr_addr"}, ofm_wr_addr, 0);
        chk({tag, "_sel"}, ofm_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic sample_pair(input int q, input bit dbl, input bit ovr);
        layer_sample = 1'b1;
        tick();
        layer_sample = dbl;
        chk("wb0_en", ofm_wr_en, 1);
        chk("wb0_sel", ofm_sel, 0);
        chk("wb0_addr", ofm_wr_addr, q);
        tick();
        layer_sample = 1'b0;
        chk("wb1_en", ofm_wr_en, 1);
        chk("wb1_sel", ofm_sel, 1);
        chk("wb1_addr", ofm_wr_addr, q + WOUT * WOUT);
        chk("wb_overrun", overrun, ovr);
        tick();
        chk("wb_end", ofm_wr_en, 0);
    endtask

    initial begin
        int n_rd;
        int gaps;
        bit prev;
        bit stl;

        #1 rst = 1'b0;
        #11;
        all_zero("reset");
        rst = 1'b1;
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;

        n_rd = 0;
        gaps = 0;
        prev = 1'b0;
        for (int cyc = 0; cyc < 30 && n_rd < 16; cyc++) begin
            stl = (cyc >= 6 && cyc < 9);
            stall = stl;
            #1;
            chk("rd_en", ifm_rd_en, !stl);
            chk("layer_en", layer_en, prev);
            if (!stl) begin
                chk("rd_addr", ifm_rd_addr, (n_rd % 4) * 4 + n_rd / 4);
                n_rd++;
            end else begin
                gaps++;
            end
            prev = !stl;
            tick();
        end
        stall = 1'b0;
        chk("reads", n_rd, 16);
        chk("gaps", gaps, 3);
        #1;
        chk("drain_rd_en", ifm_rd_en, 0);
        chk("drain_layer_en", layer_en, 1);
        chk("drain_busy", busy, 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", ifm_rd_en, 0);
        chk("drain_layer_en0", layer_en, 0);

        sample_pair(0, 1'b0, 1'b0);
        sample_pair(1, 1'b0, 1'b0);
        sample_pair(2, 1'b1, 1'b1);
        sample_pair(3, 1'b0, 1'b1);
        chk("done_early", done, 0);
        tick();
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_hold", done, 1);
        end
        ram_feedback = 1'b1;
        tick();
        ram_feedback = 1'b0;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        layer_sample = 1'b1;
        tick();
        layer_sample = 1'b0;
        chk("pre_rst_wr", ofm_wr_en, 1);
        chk("pre_rst_rd", ifm_rd_en, 1);
        rst = 1'b0;
        #1;
        all_zero("abort");
        tick();
        all_zero("abort_edge");
        rst = 1'b1;
        tick();
        chk("no_autostart", ifm_rd_en, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_en", ifm_rd_en, 1);
        chk("restart_addr0", ifm_rd_addr, 0);
        tick();
        chk("restart_addr1", ifm_rd_addr, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
